// File: rtl/btn_dir_ctrl.sv
// Button conditioner: sync, debounce and press-detect BTNU/D/L/R, then latch one frame-aligned direction.
// Optional BTN_HOLD_REARM_EN: held buttons re-request their direction on every idle frame_stb.
module btn_dir_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RESET_DIR       = 2
) (
  input  logic       vga_pix_clk,
  input  logic       rst,
  input  logic       frame_stb,
  input  logic       BTNU,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       BTNR,
  output logic [3:0] btn_db,
  output logic [3:0] btn_press,
  output logic [1:0] dir_out,
  output logic       dir_valid
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]     RST_DIR  = 2'(RESET_DIR);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t        state, state_n;
  logic [3:0]    raw, sync1, sync2;
  logic [CW-1:0] cnt [4];
  logic [1:0]    pending_dir, pending_n, dir_n, new_dir;
  logic          valid_n, press_any;

  assign raw = {BTNR, BTNL, BTND, BTNU};

  // Fixed priority U > D > L > R over a {R,L,D,U} bit vector.
  function automatic logic [1:0] prio_dir(input logic [3:0] b);
    if (b[0])      return 2'd0;
    else if (b[1]) return 2'd1;
    else if (b[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_ff @(posedge vga_pix_clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      btn_db    <= '0;
      btn_press <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == btn_db[i]) begin
          cnt[i]       <= '0;
          btn_press[i] <= 1'b0;
        end else if (cnt[i] == CNT_LAST) begin
          // Counter saturated while still differing: accept the new level.
          cnt[i]       <= '0;
          btn_db[i]    <= ~btn_db[i];
          btn_press[i] <= ~btn_db[i];
        end else begin
          cnt[i]       <= cnt[i] + CW'(1);
          btn_press[i] <= 1'b0;
        end
      end
    end
  end

  assign press_any = |btn_press;
  assign new_dir   = prio_dir(btn_press);

  always_ff @(posedge vga_pix_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending_dir <= RST_DIR;
      dir_out     <= RST_DIR;
      dir_valid   <= 1'b0;
    end else begin
      state       <= state_n;
      pending_dir <= pending_n;
      dir_out     <= dir_n;
      dir_valid   <= valid_n;
    end
  end

  // A press coinciding with frame_stb bypasses the pending slot entirely.
  always_comb begin
    state_n   = state;
    pending_n = pending_dir;
    dir_n     = dir_out;
    valid_n   = 1'b0;
    if (frame_stb && press_any) begin
      state_n = IDLE;
      dir_n   = new_dir;
      valid_n = 1'b1;
    end else if (frame_stb) begin
      state_n = IDLE;
      if (state == PENDING) begin
        dir_n   = pending_dir;
        valid_n = 1'b1;
      end else begin
`ifdef BTN_HOLD_REARM_EN
        if (|btn_db) begin
          dir_n   = prio_dir(btn_db);
          valid_n = 1'b1;
        end
`endif
      end
    end else if (press_any) begin
      state_n   = PENDING;
      pending_n = new_dir;
    end
  end

endmodule

// File: tb/tb_btn_dir_ctrl.sv
// Self-checking bench for btn_dir_ctrl with DEBOUNCE_CYCLES=4, RESET_DIR=2.
module tb_btn_dir_ctrl;

  logic       vga_pix_clk = 1'b0;
  logic       rst;
  logic       frame_stb;
  logic [3:0] btns;
  logic [3:0] btn_db, btn_press;
  logic [1:0] dir_out;
  logic       dir_valid;

  int tests = 0;
  int fails = 0;
  int valid_count = 0;
  int press_count = 0;
  logic prev_valid = 1'b0;
  logic consec_seen = 1'b0;

  btn_dir_ctrl #(.DEBOUNCE_CYCLES(4), .RESET_DIR(2)) dut (
    .vga_pix_clk(vga_pix_clk),
    .rst        (rst),
    .frame_stb  (frame_stb),
    .BTNU       (btns[0]),
    .BTND       (btns[1]),
    .BTNL       (btns[2]),
    .BTNR       (btns[3]),
    .btn_db     (btn_db),
    .btn_press  (btn_press),
    .dir_out    (dir_out),
    .dir_valid  (dir_valid)
  );

  always #5 vga_pix_clk = ~vga_pix_clk;

  always @(negedge vga_pix_clk) begin
    if (dir_valid) valid_count++;
    if (|btn_press) press_count++;
    if (dir_valid && prev_valid) consec_seen = 1'b1;
    prev_valid = dir_valid;
  end

  typedef struct {
    logic [3:0] btns;
    logic [3:0] exp_press;
    logic [1:0] exp_dir;
  } vec_t;

  vec_t vecs [8];

  task automatic check_output(input string name, input logic [3:0] actual, input logic [3:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge vga_pix_clk);
  endtask

  task automatic apply_stimulus(input logic [3:0] b);
    btns = b;
  endtask

  // One-cycle frame_stb; returns at the negedge after the sampling posedge.
  task automatic pulse_frame();
    frame_stb = 1'b1;
    @(negedge vga_pix_clk);
    frame_stb = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'b0001, 4'b0001, 2'd0};
    vecs[1] = '{4'b0010, 4'b0010, 2'd1};
    vecs[2] = '{4'b0100, 4'b0100, 2'd2};
    vecs[3] = '{4'b1000, 4'b1000, 2'd3};
    vecs[4] = '{4'b0110, 4'b0110, 2'd1};
    vecs[5] = '{4'b1111, 4'b1111, 2'd0};
    vecs[6] = '{4'b1100, 4'b1100, 2'd2};
    vecs[7] = '{4'b1001, 4'b1001, 2'd0};

    rst = 1'b1;
    frame_stb = 1'b0;
    btns = 4'b0000;
    cycles(3);
    rst = 1'b0;

    // Reset state and idle frames
    check_output("reset_btn_db", btn_db, 4'h0);
    check_output("reset_btn_press", btn_press, 4'h0);
    check_output("reset_dir_out", {2'b00, dir_out}, 4'h2);
    check_output("reset_dir_valid", {3'b000, dir_valid}, 4'h0);
    for (int k = 0; k < 3; k++) begin
      cycles(3);
      pulse_frame();
      check_output("idle_frame_valid", {3'b000, dir_valid}, 4'h0);
      check_output("idle_frame_dir", {2'b00, dir_out}, 4'h2);
    end
    check_output("idle_btn_db", btn_db, 4'h0);

    // Glitch of 3 cycles on BTNU is rejected
    press_count = 0;
    valid_count = 0;
    apply_stimulus(4'b0001);
    cycles(3);
    apply_stimulus(4'b0000);
    cycles(10);
    check_output("glitch_btn_db", btn_db, 4'h0);
    check_output("glitch_press_count", 4'(press_count), 4'h0);
    pulse_frame();
    cycles(1);
    check_output("glitch_valid_count", 4'(valid_count), 4'h0);

    // BTNR held: latency, press pulse, frame alignment, hold behaviour
    apply_stimulus(4'b1000);
    cycles(5);
    check_output("r_db_before", btn_db, 4'h0);
    check_output("r_press_before", btn_press, 4'h0);
    cycles(1);
    check_output("r_db_rise", btn_db, 4'h8);
    check_output("r_press_pulse", btn_press, 4'h8);
    cycles(1);
    check_output("r_press_gone", btn_press, 4'h0);
    check_output("r_valid_early", {3'b000, dir_valid}, 4'h0);
    cycles(12);
    pulse_frame();
    check_output("r_dir_out", {2'b00, dir_out}, 4'h3);
    check_output("r_dir_valid", {3'b000, dir_valid}, 4'h1);
    cycles(1);
    check_output("r_valid_one_cycle", {3'b000, dir_valid}, 4'h0);
    cycles(5);
    pulse_frame();
`ifdef BTN_HOLD_REARM_EN
    check_output("r_hold_valid", {3'b000, dir_valid}, 4'h1);
`else
    check_output("r_hold_valid", {3'b000, dir_valid}, 4'h0);
`endif
    check_output("r_hold_dir", {2'b00, dir_out}, 4'h3);
    apply_stimulus(4'b0000);
    cycles(10);
    check_output("r_release_db", btn_db, 4'h0);

    // Table: simultaneous presses, priority U > D > L > R
    foreach (vecs[v]) begin
      apply_stimulus(vecs[v].btns);
      cycles(6);
      check_output($sformatf("vec%0d_press", v), btn_press, vecs[v].exp_press);
      cycles(3);
      pulse_frame();
      check_output($sformatf("vec%0d_dir", v), {2'b00, dir_out}, {2'b00, vecs[v].exp_dir});
      check_output($sformatf("vec%0d_valid", v), {3'b000, dir_valid}, 4'h1);
      apply_stimulus(4'b0000);
      cycles(10);
    end

    // BTNL then BTNU 10 cycles later: latest press wins, one dir_valid
    valid_count = 0;
    apply_stimulus(4'b0100);
    cycles(10);
    apply_stimulus(4'b0101);
    cycles(10);
    check_output("lu_no_valid_yet", 4'(valid_count), 4'h0);
    pulse_frame();
    check_output("lu_dir", {2'b00, dir_out}, 4'h0);
    cycles(4);
    check_output("lu_valid_count", 4'(valid_count), 4'h1);
    apply_stimulus(4'b0000);
    cycles(10);

    // BTND pending, reset mid-PENDING discards everything
    apply_stimulus(4'b0010);
    cycles(8);
    check_output("d_db_before_rst", btn_db, 4'h2);
    rst = 1'b1;
    #1;
    check_output("d_rst_db", btn_db, 4'h0);
    check_output("d_rst_dir", {2'b00, dir_out}, 4'h2);
    cycles(1);
    rst = 1'b0;
    cycles(1);
    pulse_frame();
    check_output("d_frame_dir", {2'b00, dir_out}, 4'h2);
    check_output("d_frame_valid", {3'b000, dir_valid}, 4'h0);
    check_output("d_frame_db", btn_db, 4'h0);
    cycles(3);
    check_output("d_db_5", btn_db, 4'h0);
    cycles(1);
    check_output("d_db_6", btn_db, 4'h2);
    apply_stimulus(4'b0000);
    cycles(10);

    check_output("no_consecutive_valid", {3'b000, consec_seen}, 4'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_dir_ctrl.md
Name: btn_dir_ctrl

Overview:
- Conditions the four raw board buttons (BTNU/BTND/BTNL/BTNR) into a frame-aligned movement request for drawing_logic.
- Per-button processing: 2-FF synchronise, then debounce and press-edge detect.
- Presses are arbitrated into one pending direction. The pending direction is released to the game logic on frame_stb, so player direction changes only at frame boundaries.
- Sits directly upstream of drawing_logic in the vga_pix_clk domain.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable vga_pix_clk cycles required before the debounced state changes (10 ms at 25 MHz). Legal range is >= 1.
- RESET_DIR, 2: value of dir_out after reset. Encoding: 0=UP, 1=DOWN, 2=LEFT, 3=RIGHT.

Ports:
- vga_pix_clk  in  1  pixel clock; all logic runs on its rising edge
- rst  in  1  asynchronous, active-high reset
- frame_stb  in  1  one-cycle strobe at frame start (sx_aot==0 && sy_aot==0)
- BTNU  in  1  raw up button, asynchronous
- BTND  in  1  raw down button, asynchronous
- BTNL  in  1  raw left button, asynchronous
- BTNR  in  1  raw right button, asynchronous
- btn_db  out  4  debounced level, bit order {R,L,D,U}
- btn_press  out  4  one-cycle press pulse per button, same bit order
- dir_out  out  2  direction currently presented to drawing_logic
- dir_valid  out  1  one-cycle pulse: dir_out was updated this frame

Behaviour:
- Reset:
  - Asynchronous, active-high; all flops clear.
  - Outputs after reset: btn_db=0, btn_press=0, dir_out=RESET_DIR, dir_valid=0.
  - Internal: sync flops=0, debounce counters=0, FSM=IDLE, pending_dir=RESET_DIR.
  - Reset asserted mid-debounce or mid-PENDING discards everything. After release, a held button must debounce again from zero.
- Synchroniser: 2 flops per button; btn_db/btn_press use only the second-stage value.
- Debounce, per button:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - Counter clears on any cycle where synced input == btn_db[i].
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the next edge toggles btn_db[i] and clears the counter.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_db.
  - Latency, raw edge to btn_db change: exactly 2+DEBOUNCE_CYCLES cycles.
- Press detect: btn_press[i] is registered high in the same cycle btn_db[i] goes 0->1, for one cycle only. Releases produce no pulse.
- Arbitration:
  - If several btn_press bits are set in the same cycle, fixed priority applies: U > D > L > R.
  - The winner's code forms new_dir.
- FSM states: IDLE (no pending request) and PENDING (pending_dir holds an unserved request).
  - IDLE, press, no frame_stb -> PENDING; pending_dir=new_dir.
  - PENDING, press, no frame_stb -> PENDING; pending_dir overwritten with new_dir (latest press wins).
  - PENDING, frame_stb, no press -> IDLE; dir_out=pending_dir; dir_valid=1 next cycle.
  - Any state, frame_stb and press same cycle -> IDLE; dir_out=new_dir (bypass); dir_valid=1. Any older pending value is dropped.
  - IDLE, frame_stb, no press -> IDLE; dir_out unchanged; dir_valid=0 (see optional feature).
- Output timing:
  - dir_out and dir_valid are registered.
  - Both update on the edge that samples frame_stb=1, and are visible the cycle after frame_stb.
  - dir_valid is never high for two consecutive cycles.
- Re-press of the same direction still produces dir_valid at the next frame_stb; there is no suppression of identical values.

Optional Feature:
- Macro: BTN_HOLD_REARM_EN.
- Defined: in IDLE on frame_stb with no press, if any btn_db bit is 1:
  - dir_out takes the highest-priority held button (U>D>L>R);
  - dir_valid pulses.
  - A held button therefore re-requests its direction every frame.
- Undefined: only press edges create requests; holding a button yields a single dir_valid.

Test Plan (bench uses DEBOUNCE_CYCLES=4, RESET_DIR=2):
- Reset release, no buttons, 3 frame_stb pulses -> dir_out=2, dir_valid stays 0, btn_db=0.
- BTNU high 3 cycles then low -> btn_db stays 0000, no btn_press, no dir_valid (glitch rejected).
- BTNR held; frame_stb 20 cycles later:
  - btn_db[3] rises exactly 6 cycles after the BTNR edge, with a one-cycle btn_press[3];
  - the cycle after frame_stb: dir_out=3, dir_valid=1 for one cycle;
  - next frame_stb: dir_valid=0, or 1 with dir_out=3 if BTN_HOLD_REARM_EN is defined.
- BTNL and BTND pressed on the same edge -> press bits {L,D} together; at frame_stb, dir_out=1 (DOWN wins).
- Press BTNL, then BTNU 10 cycles later, then frame_stb -> dir_out=0; exactly one dir_valid.
- Press BTND; assert rst mid-PENDING for 1 cycle, then frame_stb with button still held:
  - dir_out=2, dir_valid=0, btn_db=0 (without BTN_HOLD_REARM_EN);
  - btn_db[1] re-rises 6 cycles after rst release.
